// File: rtl/conv_pkg.sv
// conv_pkg -- shared definitions for the folded convolution datapath.
//   calc_prod_w  : signed weight x zero-extended pixel product width
//   calc_lsum_w  : width of the sum of one beat's lane products
//   calc_acc_w   : accumulator width covering a full window plus bias
//   calc_beats   : beats needed to carry one window through the lanes
//   round_sat    : round-half-up by S bits, then clip to a signed width;
//                  also used by the pooling blocks
package conv_pkg;

  function automatic int calc_prod_w(input int wei_w, input int ima_w);
    return wei_w + ima_w + 1;
  endfunction

  function automatic int calc_lsum_w(input int prod_w, input int lanes);
    return prod_w + $clog2(lanes);
  endfunction

  function automatic int calc_acc_w(input int prod_w, input int num);
    return prod_w + $clog2(num) + 1;
  endfunction

  function automatic int calc_beats(input int num, input int lanes);
    return (num + lanes - 1) / lanes;
  endfunction

  // Wide enough for any accumulator the family uses; callers sign-extend.
  localparam int RS_W = 64;

  typedef struct packed {
    logic signed [RS_W-1:0] value;
    logic                   sat;
  } round_sat_t;

  // r = (acc + 2^(s-1)) >>> s, clipped to [-2^(out_w-1), 2^(out_w-1)-1].
  function automatic round_sat_t round_sat(input logic signed [RS_W-1:0] acc,
                                           input int s, input int out_w);
    round_sat_t             res;
    logic signed [RS_W-1:0] r;
    logic signed [RS_W-1:0] half;
    logic signed [RS_W-1:0] hi;
    logic signed [RS_W-1:0] lo;
    r = acc;
    if (s > 0) begin
      half = 64'sd1 <<< (s - 1);
      r    = (acc + half) >>> s;
    end
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    res.value = r;
    res.sat   = 1'b0;
    if (r > hi) begin
      res.value = hi;
      res.sat   = 1'b1;
    end else if (r < lo) begin
      res.value = lo;
      res.sat   = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/conv_lane_sum.sv
// conv_lane_sum -- product stage of the folded MAC.
// LANES signed-weight x unsigned-pixel multipliers, masking of the lanes
// that fall past the end of the window on its last beat, and the product
// register with its first/last beat tags. lane_sum is the adder tree over
// the registered products.
//   clk, rst     : clock, async active-high reset
//   adv          : global pipeline advance (stage updates only when set)
//   fire         : a beat is accepted this cycle
//   first, last  : position of the accepted beat within its window
//   wei, ima     : lane l at [l*WEI_W +: WEI_W] / [l*IMA_W +: IMA_W]
//   p_valid      : registered products hold a beat
//   p_first/last : tags of that beat
//   lane_sum     : signed sum of the registered products
module conv_lane_sum
  import conv_pkg::*;
#(
  parameter  int NUM    = 49,
  parameter  int LANES  = 7,
  parameter  int WEI_W  = 16,
  parameter  int IMA_W  = 8,
  localparam int PROD_W = calc_prod_w(WEI_W, IMA_W),
  localparam int LSUM_W = calc_lsum_w(PROD_W, LANES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     adv,
  input  logic                     fire,
  input  logic                     first,
  input  logic                     last,
  input  logic [WEI_W*LANES-1:0]   wei,
  input  logic [IMA_W*LANES-1:0]   ima,
  output logic                     p_valid,
  output logic                     p_first,
  output logic                     p_last,
  output logic signed [LSUM_W-1:0] lane_sum
);

  localparam int BEATS      = calc_beats(NUM, LANES);
  // Lanes at or above this index carry no tap on the last beat.
  localparam int LAST_LANES = NUM - (BEATS - 1) * LANES;

  logic signed [PROD_W-1:0] prod_d [LANES];
  logic signed [PROD_W-1:0] prod_q [LANES];

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      // NOTE: a default before the conditional keeps every path assigned, so no latch is inferred.
      prod_d[l] = '0;
      if (!(last && l >= LAST_LANES)) begin
        prod_d[l] = $signed({{(PROD_W-WEI_W){wei[l*WEI_W+WEI_W-1]}}, wei[l*WEI_W +: WEI_W]})
                  * $signed({{(PROD_W-IMA_W){1'b0}}, ima[l*IMA_W +: IMA_W]});
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_valid <= 1'b0;
      p_first <= 1'b0;
      p_last  <= 1'b0;
      // NOTE: this bank is a handful of flops, not a RAM macro, so it resets with the rest; a true memory would not.
      for (int l = 0; l < LANES; l++) prod_q[l] <= '0;
    end else if (adv) begin
      p_valid <= fire;
      if (fire) begin
        p_first <= first;
        p_last  <= last;
        for (int l = 0; l < LANES; l++) prod_q[l] <= prod_d[l];
      end
    end
  end

  always_comb begin
    lane_sum = '0;
    // NOTE: blocking '=' is required so each iteration adds onto the previous partial sum.
    for (int l = 0; l < LANES; l++) lane_sum = lane_sum + LSUM_W'(prod_q[l]);
  end

endmodule

// File: rtl/conv_mac_fold.sv
// conv_mac_fold -- time-folded convolution MAC engine.
// Takes a window of NUM weight/pixel pairs as BEATS beats of LANES pairs,
// accumulates them onto a bias, rounds/saturates/optionally ReLUs, and
// presents one result per window. A single global stall (adv) freezes every
// stage while a finished result is waiting for the consumer.
//   clk, rst           : clock, async active-high reset
//   in_valid/in_ready  : beat handshake; in_wei/in_ima carry LANES lanes
//   in_bias, in_relu   : taken on the first beat of each window
//   out_valid/out_ready: result handshake
//   out_data           : rounded, saturated, optionally ReLU'd result
//   out_acc            : full-precision accumulator (FRAC fractional bits)
//   out_sat            : out_data was clipped by saturation
module conv_mac_fold
  import conv_pkg::*;
#(
  parameter  int NUM      = 49,
  parameter  int LANES    = 7,
  parameter  int WEI_W    = 16,
  parameter  int IMA_W    = 8,
  parameter  int FRAC     = 8,
  parameter  int OUT_FRAC = 4,
  parameter  int OUT_W    = 16,
  localparam int PROD_W   = calc_prod_w(WEI_W, IMA_W),
  localparam int ACC_W    = calc_acc_w(PROD_W, NUM)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WEI_W*LANES-1:0] in_wei,
  input  logic [IMA_W*LANES-1:0] in_ima,
  input  logic [WEI_W-1:0]       in_bias,
  input  logic                   in_relu,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic [ACC_W-1:0]       out_acc,
  output logic                   out_sat
);

  localparam int BEATS  = calc_beats(NUM, LANES);
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LSUM_W = calc_lsum_w(PROD_W, LANES);
  localparam int SHIFT  = FRAC - OUT_FRAC;

  logic                     adv;
  logic                     fire;
  logic [CNT_W-1:0]         beat_cnt;
  logic                     beat_first;
  logic                     beat_last;
  logic signed [WEI_W-1:0]  bias_p;
  logic                     relu_p;
  logic                     p_valid;
  logic                     p_first;
  logic                     p_last;
  logic signed [LSUM_W-1:0] lane_sum;
  logic                     a_valid;
  logic                     a_last;
  logic                     relu_a;
  logic signed [ACC_W-1:0]  acc;
  round_sat_t               rs;
  logic [OUT_W-1:0]         res_data;

  // A held result that the consumer is not taking freezes the whole pipe.
  assign adv        = !out_valid || out_ready;
  assign in_ready   = adv;
  assign fire       = in_valid && adv;
  assign beat_first = (beat_cnt == '0);
  assign beat_last  = (beat_cnt == CNT_W'(BEATS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      bias_p   <= '0;
      relu_p   <= 1'b0;
    end else if (fire) begin
      // NOTE: non-blocking '<=' so every register samples pre-edge values, as the hardware does.
      beat_cnt <= beat_last ? '0 : beat_cnt + CNT_W'(1);
      // Bias/relu ride alongside the first beat's products into stage A.
      if (beat_first) begin
        bias_p <= in_bias;
        relu_p <= in_relu;
      end
    end
  end

  conv_lane_sum #(
    .NUM   (NUM),
    .LANES (LANES),
    .WEI_W (WEI_W),
    .IMA_W (IMA_W)
  ) u_lane_sum (
    .clk      (clk),
    .rst      (rst),
    .adv      (adv),
    .fire     (fire),
    .first    (beat_first),
    .last     (beat_last),
    .wei      (in_wei),
    .ima      (in_ima),
    .p_valid  (p_valid),
    .p_first  (p_first),
    .p_last   (p_last),
    .lane_sum (lane_sum)
  );

  // Stage A: accumulate; a first beat restarts from the window's bias.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid <= 1'b0;
      a_last  <= 1'b0;
      relu_a  <= 1'b0;
      acc     <= '0;
    end else if (adv) begin
      a_valid <= p_valid;
      if (p_valid) begin
        a_last <= p_last;
        if (p_first) begin
          acc    <= ACC_W'(bias_p) + ACC_W'(lane_sum);
          relu_a <= relu_p;
        end else begin
          acc <= acc + ACC_W'(lane_sum);
        end
      end
    end
  end

  always_comb begin
    rs       = round_sat({{(RS_W-ACC_W){acc[ACC_W-1]}}, acc}, SHIFT, OUT_W);
    res_data = rs.value[OUT_W-1:0];
    // ReLU only zeroes the value; the clip flag still reports saturation.
    if (relu_a && rs.value < 0) res_data = '0;
  end

  // Stage O: capture a finished window; when adv is set the old result is
  // either absent or being taken this edge, so it can be replaced freely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_acc   <= '0;
      out_sat   <= 1'b0;
    end else if (adv) begin
      out_valid <= a_valid && a_last;
      if (a_valid && a_last) begin
        out_data <= res_data;
        out_acc  <= acc;
        out_sat  <= rs.sat;
      end
    end
  end

endmodule

// File: doc/conv_mac_fold.md
# conv_mac_fold

Parametrised, time-folded convolution MAC engine, successor to the fixed 49-multiplier kernel core. It accepts a kernel window of NUM weight/pixel pairs as BEATS = ceil(NUM/LANES) beats of LANES pairs each, and accumulates them with a bias. It then rounds, saturates and optionally applies ReLU, presenting one result per window. Valid/ready handshakes on both sides let it sit between the line-buffer/weight streamer and the feature-map writer with full backpressure.

## Interface
- NUM, 49: taps per window (kernel size).
- LANES, 7: weight/pixel pairs per beat; 1 ≤ LANES ≤ NUM.
- WEI_W, 16: signed weight and bias width, FRAC fractional bits.
- IMA_W, 8: unsigned integer pixel width.
- FRAC, 8: fractional bits of weight, bias and accumulator.
- OUT_FRAC, 4: fractional bits of out_data; OUT_FRAC ≤ FRAC.
- OUT_W, 16: signed output width.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  beat present.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_wei  in  WEI_W*LANES  lane l at [l*WEI_W +: WEI_W].
- in_ima  in  IMA_W*LANES  lane l at [l*IMA_W +: IMA_W].
- in_bias  in  WEI_W  sampled on the window's first beat only.
- in_relu  in  1  sampled on the window's first beat only.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts.
- out_data  out  OUT_W  rounded, saturated, optionally ReLU'd result.
- out_acc  out  ACC_W  full-precision accumulator (FRAC fractional bits).
- out_sat  out  1  out_data was clipped by saturation.

## Operation
- Widths: PROD_W = WEI_W+IMA_W+1. The pixel is zero-extended and the product is signed. LSUM_W = PROD_W+clog2(LANES). ACC_W = PROD_W+clog2(NUM)+1. Defaults: 25/28/32. No internal overflow is possible.
- Beat counter: 0..BEATS-1, advances on each accepted beat, wraps to 0 after the last beat.
- On the last beat, lanes with index l ≥ NUM-(BEATS-1)*LANES are forced to zero product regardless of input.
- Stage P: registers LANES products plus a beat-tag (first, last).
- Stage A:
  - First beat: acc ← sext(bias) + lane_sum.
  - Otherwise: acc ← acc + lane_sum.
  - relu flag is latched with the first beat.
- Stage O, when stage A completes a last beat:
  - r = (acc + (1 << (S-1))) >>> S, with S = FRAC-OUT_FRAC. Round-half-up; no rounding term when S = 0.
  - Saturate r to signed OUT_W and set out_sat if clipped.
  - If relu is set and the result is negative, out_data = 0. ReLU zeroing never sets out_sat.
  - out_acc = acc.
- Global stall: adv = !out_valid || out_ready. All stages (P, A, counter, O) update only when adv. in_ready = adv (a combinational path from out_ready is accepted).
- Reset, including mid-window: counter 0, all stage valids 0, acc 0, out_valid 0, out_data 0, out_acc 0, out_sat 0, in_ready 1 once released. The partial window is discarded.

## Timing
- Throughput: one beat per cycle. Back-to-back windows run with no bubble; the new window's first beat may enter stage A on the same edge the previous result is captured into O.
- Latency: last beat accepted at edge k → product registered k, acc final k+1, out_valid high after edge k+2.
- out_valid && !out_ready: out_data, out_acc and out_sat are held stable, in_ready is 0, and nothing in the pipeline moves.
- out_valid && out_ready with a new result arriving: the new result replaces the old on the same edge, and out_valid stays 1.

## Structure
- Shared package conv_pkg holds:
  - the width functions PROD_W, LSUM_W, ACC_W and BEATS;
  - a round_sat function (acc, S, OUT_W → value, sat flag) reused by later pooling blocks.
- One sub-module, conv_lane_sum, owns the LANES signed×unsigned multipliers, the last-beat masking and the registered product stage. It outputs lane_sum and the tags.

## Test plan
- Defaults; all weights 0x0100, pixels 1, bias 0, relu 0; 7 beats → acc 12544, out_data 0x0310, out_sat 0, out_valid 2 cycles after 7th beat.
- All weights 0x7FFF, pixels 255, bias 0x7FFF → out_data 0x7FFF, out_sat 1. Weights 0x8000, bias 0x8000 → 0x8000, out_sat 1.
- Weights 0xFF00, pixels 2, bias 0: relu 0 → out_data 0xF9E0, out_sat 0. Same window with relu 1 → 0x0000, out_sat 0.
- Rounding: lane 0 of beat 0 only; weight 0x0008, pixel 1 → out_data 0x0001. Weight 0x0007 → 0x0000.
- Backpressure: two windows streamed, out_ready low for 10 cycles after first result → in_ready 0 and outputs stable; then release → both results delivered in order, none lost or duplicated.
- NUM=10, LANES=4 (BEATS 3): drive 0x7FFF/255 on lanes 2–3 of beat 2 → result unaffected. Assert rst after beat 1 of a window → all outputs 0; next full window yields its correct result.
